// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// buffers the instruction across decode stalls and squashes wrong-path slots on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_2000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_dout,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] hold_instr;
  logic [31:0] redirect_addr;
  logic [31:0] pc_next;

  assign redirect_addr = {redirect_pc[31:2], 2'b00};
  assign pc_next       = pc_f + 32'd4;

  // Redirect outranks stall: a squashed slot never needs holding.
  always_comb begin
    imem_addr   = pc_next;
    imem_en     = 1'b1;
    instr_out   = imem_dout;
    pc_out      = pc_f;
    instr_valid = 1'b1;
    case (state)
      RUN, HOLD: begin
        if (state == HOLD) instr_out = hold_instr;
        if (redirect_valid) begin
          instr_out   = NOP_INSTR;
          instr_valid = 1'b0;
          imem_addr   = redirect_addr;
        end else if (stall) begin
          imem_en   = 1'b0;
          imem_addr = pc_f;
        end
      end
      default: begin
        imem_addr   = RESET_PC;
        instr_out   = NOP_INSTR;
        instr_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_f        <= RESET_PC;
      hold_instr  <= NOP_INSTR;
      instr_count <= 32'd0;
    end else begin
      if (instr_valid && !stall && !redirect_valid)
        instr_count <= instr_count + 32'd1;
      case (state)
        RUN: begin
          if (redirect_valid) begin
            pc_f <= redirect_addr;
          end else if (stall) begin
            hold_instr <= imem_dout;
            state      <= HOLD;
          end else begin
            pc_f <= pc_next;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_f  <= redirect_addr;
            state <= RUN;
          end else if (!stall) begin
            pc_f  <= pc_next;
            state <= RUN;
          end
        end
        default: begin
          pc_f  <= RESET_PC;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem model returns addr ^ 32'hA5A5_0000 one cycle after an enabled read.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_dout = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  // Observed bundle: {instr_out, pc_out, instr_valid, imem_en, imem_addr}
  logic [97:0] obs;
  assign obs = {instr_out, pc_out, instr_valid, imem_en, imem_addr};

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_dout(imem_dout), .imem_addr(imem_addr),
    .imem_en(imem_en), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_dout <= imem_addr ^ 32'hA5A5_0000;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000}) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", obs,
               {32'h0000_0013, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000});
    end
    total++;
    if (instr_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_count got=%h want=0", instr_count);
    end
    rst = 1'b0;
  endtask

  // Ends positioned in the cycle presenting pc 0x2008 (not yet accepted).
  task automatic test_free_run();
    logic [31:0] pcs [3];
    pcs[0] = 32'h2000; pcs[1] = 32'h2004; pcs[2] = 32'h2008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (obs !== {pcs[i] ^ 32'hA5A5_0000, pcs[i], 1'b1, 1'b1, pcs[i] + 32'd4}) begin
        bad++;
        $display("[TB] FAIL free_run[%0d] got=%h want=%h", i, obs,
                 {pcs[i] ^ 32'hA5A5_0000, pcs[i], 1'b1, 1'b1, pcs[i] + 32'd4});
      end
      total++;
      if (instr_count !== i) begin
        bad++;
        $display("[TB] FAIL free_run_count[%0d] got=%0d want=%0d", i, instr_count, i);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (obs !== {32'hA5A5_2008, 32'h2008, 1'b1, 1'b0, 32'h2008}) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d] got=%h want=%h", i, obs,
                 {32'hA5A5_2008, 32'h2008, 1'b1, 1'b0, 32'h2008});
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    total++;
    if (obs !== {32'hA5A5_2008, 32'h2008, 1'b1, 1'b1, 32'h200C}) begin
      bad++;
      $display("[TB] FAIL stall_release got=%h want=%h", obs,
               {32'hA5A5_2008, 32'h2008, 1'b1, 1'b1, 32'h200C});
    end
    total++;
    if (instr_count !== 32'd2) begin
      bad++;
      $display("[TB] FAIL stall_count_held got=%0d want=2", instr_count);
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_200C, 32'h200C, 1'b1, 1'b1, 32'h2010} || instr_count !== 32'd3) begin
      bad++;
      $display("[TB] FAIL stall_after got=%h cnt=%0d want pc=200c cnt=3", obs, instr_count);
    end
    @(negedge clk);
  endtask

  // Entered in the cycle presenting pc 0x2010 with count 4.
  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3003;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h2010, 1'b0, 1'b1, 32'h3000}) begin
      bad++;
      $display("[TB] FAIL redirect_squash got=%h want=%h", obs,
               {32'h0000_0013, 32'h2010, 1'b0, 1'b1, 32'h3000});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if (obs !== {32'hA5A5_3000, 32'h3000, 1'b1, 1'b1, 32'h3004} || instr_count !== 32'd4) begin
      bad++;
      $display("[TB] FAIL redirect_target got=%h cnt=%0d want pc=3000 cnt=4", obs, instr_count);
    end
    @(negedge clk);
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    #1;
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_3004, 32'h3004, 1'b1, 1'b0, 32'h3004} || instr_count !== 32'd5) begin
      bad++;
      $display("[TB] FAIL hold_before_redirect got=%h cnt=%0d want pc=3004 cnt=5", obs, instr_count);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h3004, 1'b0, 1'b1, 32'h4000}) begin
      bad++;
      $display("[TB] FAIL redirect_stall_squash got=%h want=%h", obs,
               {32'h0000_0013, 32'h3004, 1'b0, 1'b1, 32'h4000});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    total++;
    if (obs !== {32'hA5A5_4000, 32'h4000, 1'b1, 1'b1, 32'h4004} || instr_count !== 32'd5) begin
      bad++;
      $display("[TB] FAIL redirect_stall_target got=%h cnt=%0d want pc=4000 cnt=5", obs, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h4000, 1'b0, 1'b1, 32'h5000}) begin
      bad++;
      $display("[TB] FAIL b2b_first got=%h want=%h", obs,
               {32'h0000_0013, 32'h4000, 1'b0, 1'b1, 32'h5000});
    end
    @(negedge clk);
    redirect_pc = 32'h0000_6004;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h5000, 1'b0, 1'b1, 32'h6004}) begin
      bad++;
      $display("[TB] FAIL b2b_second got=%h want=%h", obs,
               {32'h0000_0013, 32'h5000, 1'b0, 1'b1, 32'h6004});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if (obs !== {32'hA5A5_6004, 32'h6004, 1'b1, 1'b1, 32'h6008} || instr_count !== 32'd5) begin
      bad++;
      $display("[TB] FAIL b2b_target got=%h cnt=%0d want pc=6004 cnt=5", obs, instr_count);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h6004, 1'b0, 1'b1, 32'hFFFF_FFFC}) begin
      bad++;
      $display("[TB] FAIL wrap_redirect got=%h want=%h", obs,
               {32'h0000_0013, 32'h6004, 1'b0, 1'b1, 32'hFFFF_FFFC});
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    force dut.instr_count = 32'hFFFF_FFFE;
    #1;
    release dut.instr_count;
    #1;
    total++;
    if (instr_count !== 32'hFFFF_FFFE) begin
      bad++;
      $display("[TB] FAIL wrap_preload got=%h want=fffffffe", instr_count);
    end
    total++;
    if (obs !== {32'h5A5A_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000}) begin
      bad++;
      $display("[TB] FAIL wrap_pc got=%h want=%h", obs,
               {32'h5A5A_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000});
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_0000, 32'h0, 1'b1, 1'b1, 32'h4} || instr_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("[TB] FAIL wrap_zero got=%h cnt=%h want pc=0 cnt=ffffffff", obs, instr_count);
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_0004, 32'h4, 1'b1, 1'b1, 32'h8} || instr_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL wrap_count got=%h cnt=%h want pc=4 cnt=0", obs, instr_count);
    end
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1;
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_0004, 32'h4, 1'b1, 1'b0, 32'h4}) begin
      bad++;
      $display("[TB] FAIL rst_hold_pre got=%h want=%h", obs,
               {32'hA5A5_0004, 32'h4, 1'b1, 1'b0, 32'h4});
    end
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    total++;
    if (obs !== {32'h0000_0013, 32'h2000, 1'b0, 1'b1, 32'h2000} || instr_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL rst_hold_boot got=%h cnt=%0d want boot cnt=0", obs, instr_count);
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_2000, 32'h2000, 1'b1, 1'b1, 32'h2004} || instr_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL rst_hold_first got=%h cnt=%0d want pc=2000 cnt=0", obs, instr_count);
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {32'hA5A5_2004, 32'h2004, 1'b1, 1'b1, 32'h2008} || instr_count !== 32'd1) begin
      bad++;
      $display("[TB] FAIL rst_hold_second got=%h cnt=%0d want pc=2004 cnt=1", obs, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
